// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster defaults shared by the timing slice.
// Sync windows are expressed as start position plus pulse length.
package vga_timing_pkg;
  localparam int CNT_W   = 10;
  localparam int FRAME_W = 11;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam bit VGA_H_SYNC_POL = 1'b0;
  localparam bit VGA_V_SYNC_POL = 1'b0;

  localparam int VGA_H_TOTAL =
    VGA_H_DISPLAY + VGA_H_FRONT +
    VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL =
    VGA_V_DISPLAY + VGA_V_FRONT +
    VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_H_SYNC_START =
    VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END =
    VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START =
    VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END =
    VGA_V_SYNC_START + VGA_V_SYNC - 1;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis with wrap, sync window and wrap pulse.
// Flags are registered from the next count so they line up with o_cnt.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = VGA_H_TOTAL,
  parameter int SYNC_START = VGA_H_SYNC_START,
  parameter int SYNC_LEN   = VGA_H_SYNC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last,
  output logic             o_sync,
  output logic             o_wrap
);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SS =
    CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SE =
    CNT_W'(SYNC_START + SYNC_LEN - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next;
  logic             r_sync;
  logic             r_wrap;
  logic             w_last;
  logic             w_in_win;

  // next count and sync window of that next count
  always_comb begin
    w_last = (r_cnt == LAST);
    w_next = r_cnt;
    if (i_adv)
      w_next = w_last ? '0 : r_cnt + 1'b1;
    w_in_win = (w_next >= SS) && (w_next <= SE);
  end

  // counter, sync flag and wrap pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sync <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_next;
      r_sync <= w_in_win;
      r_wrap <= i_adv && w_last;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = w_last;
  assign o_sync = r_sync;
  assign o_wrap = r_wrap;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing, strobes and frame counter.
// Define VGA_TIMING_FRAME_COUNTER_EN to build the 11-bit frame register.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = VGA_H_DISPLAY,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_DISPLAY  = VGA_V_DISPLAY,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter bit H_SYNC_POL = VGA_H_SYNC_POL,
  parameter bit V_SYNC_POL = VGA_V_SYNC_POL
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         hsync,
  output logic         vsync,
  output logic         display_on,
  output logic [9:0]   hpos,
  output logic [9:0]   vpos,
  output logic         line_start,
  output logic         frame_start,
  output logic [10:0]  frame
);
  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_VIS =
    CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS =
    CNT_W'(V_DISPLAY);

  if (H_TOTAL > CNT_MAX) begin : g_h_err
    $error("H_TOTAL exceeds 10-bit counter");
  end
  if (V_TOTAL > CNT_MAX) begin : g_v_err
    $error("V_TOTAL exceeds 10-bit counter");
  end

  logic w_h_last;
  logic w_h_sync;
  logic w_h_wrap;
  logic w_v_last;
  logic w_v_sync;
  logic w_v_wrap;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_LEN   (H_SYNC)
  ) u_h (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_adv  (1'b1),
    .o_cnt  (hpos),
    .o_last (w_h_last),
    .o_sync (w_h_sync),
    .o_wrap (w_h_wrap)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_DISPLAY + V_FRONT),
    .SYNC_LEN   (V_SYNC)
  ) u_v (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_adv  (w_h_last),
    .o_cnt  (vpos),
    .o_last (w_v_last),
    .o_sync (w_v_sync),
    .o_wrap (w_v_wrap)
  );

  assign hsync = w_h_sync ? H_SYNC_POL : ~H_SYNC_POL;
  assign vsync = w_v_sync ? V_SYNC_POL : ~V_SYNC_POL;
  assign line_start  = w_h_wrap;
  assign frame_start = w_v_wrap;
  assign display_on  = (hpos < H_VIS) && (vpos < V_VIS);

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  logic [FRAME_W-1:0] r_frame;

  // frame count bumps on the edge that raises frame_start
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_frame <= '0;
    else if (w_h_last && w_v_last)
      r_frame <= r_frame + 1'b1;
  end

  assign frame = r_frame;
`else
  assign frame = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-reset raster check against a cycle-count model.
// Uses a reduced raster so several frames fit in a short run.
module tb_vga_timing_gen;
  localparam int HD = 20, HF = 4, HS = 6, HB = 2;
  localparam int VD = 12, VF = 2, VS = 3, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk;
  logic        rst_n;
  logic        hsync, vsync, display_on;
  logic [9:0]  hpos, vpos;
  logic        line_start, frame_start;
  logic [10:0] frame;

  int t;
  int n_cmp;
  int n_bad;
  int fs_seen, fs_exp;
  int vmax_seen;

  vga_timing_gen #(
    .H_DISPLAY (HD), .H_FRONT (HF),
    .H_SYNC    (HS), .H_BACK  (HB),
    .V_DISPLAY (VD), .V_FRONT (VF),
    .V_SYNC    (VS), .V_BACK  (VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .hpos        (hpos),
    .vpos        (vpos),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame       (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0d",
             tag, obs, exp, t);
    end
  endtask

  task automatic check_model();
    int h, v, f;
    bit ls, fs;
    h  = t % HT;
    v  = (t / HT) % VT;
    ls = (t > 0) && (h == 0);
    fs = (t > 0) && (t % FT == 0);
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    f = (t / FT) % 2048;
`else
    f = 0;
`endif
    chk("hpos", 32'(hpos), h);
    chk("vpos", 32'(vpos), v);
    chk("hsync", 32'(hsync),
        (h >= HD + HF && h < HD + HF + HS) ? 0 : 1);
    chk("vsync", 32'(vsync),
        (v >= VD + VF && v < VD + VF + VS) ? 0 : 1);
    chk("display_on", 32'(display_on),
        (h < HD && v < VD) ? 1 : 0);
    chk("line_start", 32'(line_start), 32'(ls));
    chk("frame_start", 32'(frame_start), 32'(fs));
    chk("frame", 32'(frame), f);
    if (frame_start === 1'b1) fs_seen++;
    if (fs) fs_exp++;
    if (int'(vpos) > vmax_seen) vmax_seen = int'(vpos);
  endtask

  task automatic step(input bit r);
    @(negedge clk);
    check_model();
    rst_n = r;
    @(posedge clk);
    if (!r) t = 0;
    else t++;
  endtask

  initial begin
    int guard;
    n_cmp = 0; n_bad = 0;
    fs_seen = 0; fs_exp = 0;
    vmax_seen = 0;
    t = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    // hold reset, then release and run two full frames
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 2 * FT + 5; i++)
      step(1'b1);

    // reset inside the hsync window mid-frame
    guard = 0;
    while (!((t % HT) == HD + HF + 4 &&
             ((t / HT) % VT) == 8) &&
           guard < 2 * FT) begin
      step(1'b1);
      guard++;
    end
    chk("reach_midframe", guard < 2 * FT, 1);
    step(1'b0);
    for (int i = 0; i < FT + 3; i++)
      step(1'b1);

    // long run with sparse random resets
    for (int i = 0; i < 20000; i++)
      step($urandom_range(0, 999) != 0);

    @(negedge clk);
    chk("frame_start_count", fs_seen, fs_exp);
    chk("vpos_max", vmax_seen, VT - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream stage of the VGA effect pipeline. Generates 640x480@60 Hz raster timing (25.175 MHz pixel clock): pixel/line counters, sync pulses, active-video flag, line/frame strobes and a free-running frame counter. Its outputs feed the rotation accumulators, Bayer dither and TinyVGA PMOD packing. All outputs are registered, or decoded only from registered counters; none depends combinationally on inputs.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active-low)
V_SYNC_POL, 0, vsync active level (0 = active-low)

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous reset, active-low
hsync  out  1  horizontal sync at H_SYNC_POL active level
vsync  out  1  vertical sync at V_SYNC_POL active level
display_on  out  1  high inside the 640x480 visible area
hpos  out  10  current pixel column, 0..H_TOTAL-1
vpos  out  10  current line, 0..V_TOTAL-1
line_start  out  1  one-cycle pulse on the cycle where hpos==0
frame_start  out  1  one-cycle pulse on the cycle where hpos==0 && vpos==0 (wrap only)
frame  out  11  frame counter (see Optional Feature)

Behaviour:
- Clock and reset: clk; rst_n is synchronous, active-low. Reset is sampled on the clk edge only.
- Derived constants: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Reset values: hpos=0, vpos=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, line_start=0, frame_start=0, frame=0. display_on is decoded, so it reads 1 during reset.
- Counters: hpos increments every cycle. At hpos==H_TOTAL-1 it wraps to 0 and vpos increments. vpos wraps to 0 when hpos==H_TOTAL-1 && vpos==V_TOTAL-1.
- Sync: hsync/vsync are registered from next-state counter values, so they align with the hpos/vpos shown in the same cycle.
  - hsync is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
  - vsync is active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491], for every hpos of those lines.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY); zero latency relative to the counters.
- Strobes: line_start and frame_start are registered and set from next-state counters.
  - Neither asserts in the first cycle after reset release. The first line_start comes at the first hpos wrap (800 cycles after release); the first frame_start at 525*800 = 420000 cycles.
  - frame_start implies line_start in the same cycle.
- Frame counter: increments on the same edge that raises frame_start, so the new value is visible in the frame_start cycle. 11-bit wrap: 2047 -> 0.
- Reset mid-frame: everything returns to reset values on the next edge. No partial strobes follow.
- Width rule: counters are 10 bits; the design must elaborate with an error if H_TOTAL or V_TOTAL exceeds 1024.

Optional Feature:
VGA_TIMING_FRAME_COUNTER_EN
- Defined: the 11-bit frame register exists and behaves as above.
- Undefined: no register is built; frame is tied to 0. frame_start remains available so downstream logic can keep its own count.

Decomposition:
- vga_timing_pkg holds:
  - the 640x480@60 default constants (H/V display, porches, sync widths, totals);
  - the polarity constants;
  - localparams for sync start/end positions.
- One natural sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical). Each instance provides:
  - a wrapping counter with an advance enable;
  - a registered sync-window flag;
  - a registered wrap pulse.

Test Plan:
- Reset released at cycle 0 -> hpos=0, vpos=0, hsync=1, vsync=1, line_start=0, frame_start=0, frame=0; cycle 1 hpos=1.
- Run one line -> hsync low exactly for hpos 656..751 (96 cycles); display_on high for hpos 0..639 on vpos 0; line_start high only at hpos=0 of vpos=1 (cycle 800).
- Run a full frame -> vsync low only on vpos 490 and 491 (1600 cycles); display_on never high for vpos>=480; vpos max 524; frame_start and frame=1 at cycle 420000.
- Run 2048 frames (or force counter to 2047 with a test hook) -> frame wraps to 0 on the frame_start cycle.
- Assert rst_n=0 at hpos=700, vpos=300 for one cycle -> next cycle all outputs at reset values; no spurious line_start or frame_start.
- Build without VGA_TIMING_FRAME_COUNTER_EN -> frame stays 0 through 3 frames; frame_start still pulses every 420000 cycles.
